pe_addsub_pipe: RTL
===================

# pe_addsub_pipe

Parametrised, pipelined add/subtract datapath for the PE: the next generation of the single-cycle 16-bit adder. It adds configurable width and pipeline depth, subtract and carry-in modes, optional signed saturation, and a valid/ready handshake with full-pipe stall. It produces registered C/Z/N/V flags alongside the result, so PE flag logic and the routing fabric consume aligned data and flags.

## Interface
Parameters:
- WIDTH, 16, operand/result width; legal ≥ 2.
- STAGES, 2, pipeline register stages from input to output; legal 1..4; equals latency.

Ports:
- CLK  in  1  clock; all state on rising edge.
- ASYNCRESET  in  1  reset, asynchronous, active-low; clears all state immediately, released synchronously by the driver.
- clk_en  in  1  global enable; low freezes all state and forces in_ready low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- op  in  2  00 add, 01 sub, 10 add+cin, 11 sub-with-borrow (borrow = ~cin).
- sat  in  1  1 = saturate signed overflow.
- cin  in  1  carry-in for op 10/11; ignored for 00/01.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  res/flags valid.
- out_ready  in  1  downstream accepts.
- res  out  WIDTH  result.
- flag_c  out  1  carry out (sub: 1 = no borrow).
- flag_z  out  1  res == 0.
- flag_n  out  1  res[WIDTH-1].
- flag_v  out  1  signed overflow of raw sum.

## Operation
- Arithmetic is done in a WIDTH+1 unsigned adder: sum = {0,a} + {0,b'} + k.
  - op 00: b' = b, k = 0.
  - op 01: b' = ~b, k = 1.
  - op 10: b' = b, k = cin.
  - op 11: b' = ~b, k = cin.
- raw = sum[WIDTH-1:0]; flag_c = sum[WIDTH].
- flag_v = (a[msb] == b'[msb]) & (raw[msb] != a[msb]).
- Saturation: if sat & flag_v, res = a[msb] ? 1 followed by zeros (min) : 0 followed by ones (max). Otherwise res = raw.
- flag_z and flag_n are computed from the final res (post-saturation). flag_c and flag_v always reflect the raw sum.
- Pipeline: STAGES register stages, each holding {valid, res-or-intermediate, flags}. Arithmetic completes in stage 1; later stages carry it forward.
- Advance condition: adv = clk_en & (~out_valid | out_ready). When adv is high, all stages shift together. When adv is low, every stage holds, including bubbles; bubbles are not compressed.
- in_ready = adv, combinational. A beat is accepted when in_valid & in_ready.
- Stage-1 valid loads in_valid & in_ready on adv.
- Output: out_valid is the last-stage valid bit; res and flags are the last-stage registers.
- Data registers are allowed to load don't-care values when valid is 0. Res and flags must hold while out_valid & ~out_ready.

## Timing
- Reset values: out_valid 0, res 0, all flags 0, all internal valid bits 0. in_ready follows clk_en once reset is released.
- Latency: a beat accepted at edge t appears at out_valid after edge t+STAGES-1. With STAGES = 1, the result is visible the cycle after acceptance.
- Throughput: 1 beat/cycle while out_ready stays high.
- Stall: out_valid & ~out_ready drives in_ready low in the same cycle; no beat is lost or duplicated.
- Output handshake completes when out_valid & out_ready at the edge. Simultaneous accept on input and output in one cycle is legal and required.
- clk_en low: no state changes and no handshakes complete. Outputs hold their values.
- Reset asserted mid-operation: all in-flight beats are discarded. Outputs return to reset values asynchronously. The first beat after release completes with the normal STAGES latency.
- Width: no overflow beyond WIDTH+1 bits. Wrap-around is modulo 2^WIDTH unless sat applies.

## Test plan
- WIDTH=16, STAGES=2: op 00, a=0x7FFF, b=0x0001, sat=0 -> res 0x8000, V=1, N=1, C=0, Z=0, out_valid 2 cycles after accept. Same beat with sat=1 -> res 0x7FFF, V=1, N=0.
- op 00, a=0xFFFF, b=0x0001 -> res 0x0000, C=1, Z=1, V=0, N=0. op 10, a=0xFFFE, b=0x0001, cin=1 -> res 0x0000, C=1, Z=1.
- op 01, a=0x0005, b=0x0007 -> res 0xFFFE, C=0, N=1, V=0. op 01, a=0x8000, b=0x0001, sat=1 -> res 0x8000, V=1, N=1.
- Stream 8 beats back-to-back with out_ready held low for cycles 3-5: in_ready drops during the stall, and all 8 results emerge in order with no loss or duplication.
- Pull ASYNCRESET low with 2 beats in flight: out_valid and flags go to 0 at once. After release, one new beat completes with latency 2.
- Hold clk_en low for 4 cycles with a valid output and out_ready high: output holds, no handshake completes, and the stream resumes unchanged.

Source files
------------

// File: rtl/pe_addsub_pipe.sv
// Pipelined add/subtract datapath with carry-in, optional signed saturation,
// registered C/Z/N/V flags and a valid/ready handshake that stalls the whole pipe.
module pe_addsub_pipe #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 2
) (
   input  logic             CLK,
   input  logic             ASYNCRESET,
   input  logic             clk_en,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic             sat,
   input  logic             cin,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic             flag_c,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_v
);

   typedef struct packed {
      logic [WIDTH-1:0] res;
      logic             c;
      logic             z;
      logic             n;
      logic             v;
   } stage_t;

   logic [STAGES:1]  vld_pipe;
   stage_t           dat_pipe [1:STAGES];
   stage_t           s1_d;
   logic             adv;
   logic             accept;
   logic             k;
   logic [WIDTH-1:0] b_x;
   logic [WIDTH-1:0] raw;
   logic [WIDTH-1:0] sat_val;
   logic [WIDTH:0]   sum;

   // Every stage, bubbles included, moves only when the output slot can drain.
   assign adv      = clk_en & (~out_valid | out_ready);
   assign in_ready = adv;
   assign accept   = in_valid & adv;

   // Subtract is a + ~b + k; op[1] selects cin as k, otherwise k is the plain sub's +1.
   assign b_x     = op[0] ? ~b : b;
   assign k       = op[1] ? cin : op[0];
   assign sum     = {1'b0, a} + {1'b0, b_x} + {{WIDTH{1'b0}}, k};
   assign raw     = sum[WIDTH-1:0];
   assign sat_val = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};

   assign s1_d.c   = sum[WIDTH];
   assign s1_d.v   = (a[WIDTH-1] == b_x[WIDTH-1]) & (raw[WIDTH-1] != a[WIDTH-1]);
   assign s1_d.res = (sat & s1_d.v) ? sat_val : raw;
   // Z and N describe the delivered result, so they follow saturation.
   assign s1_d.z   = ~|s1_d.res;
   assign s1_d.n   = s1_d.res[WIDTH-1];

   always_ff @(posedge CLK or negedge ASYNCRESET) begin
      if (!ASYNCRESET) begin
         vld_pipe <= '0;
         dat_pipe <= '{default: '0};
      end else if (adv) begin
         vld_pipe[1] <= accept;
         dat_pipe[1] <= s1_d;
         for (int s = 2; s <= STAGES; s++) begin
            vld_pipe[s] <= vld_pipe[s-1];
            dat_pipe[s] <= dat_pipe[s-1];
         end
      end
   end

   assign out_valid = vld_pipe[STAGES];
   assign res       = dat_pipe[STAGES].res;
   assign flag_c    = dat_pipe[STAGES].c;
   assign flag_z    = dat_pipe[STAGES].z;
   assign flag_n    = dat_pipe[STAGES].n;
   assign flag_v    = dat_pipe[STAGES].v;

endmodule
